apb_wait_slave: RTL and testbench
=================================

// Module: apb_wait_slave
// PURPOSE
//  APB completer (responder) with a small register bank and programmable wait states.
//  It is the target end of the APB link driven by our APB master.
//  Holds the four student-record registers plus a read-only write counter.
//  Extends the zero-wait slave with PREADY stretching and a PSLVERR response.
// PARAMETERS
//  ADDR_W       32  PADDR width
//  DATA_W       32  PWDATA/PRDATA width
//  NUM_REGS     4   RW registers at 0x0,0x4,0x8,0xC (number_in_group, date, surname, name)
//  WAIT_CYCLES  1   access-phase cycles with PREADY low before completion (0..15)
// PORTS
//  PCLK     in   1       clock, all logic on rising edge
//  PRESET   in   1       reset, synchronous, active-high
//  PSEL     in   1       completer select
//  PENABLE  in   1       access phase strobe
//  PWRITE   in   1       1 = write, 0 = read
//  PADDR    in   ADDR_W  byte address
//  PWDATA   in   DATA_W  write data
//  PRDATA   out  DATA_W  read data, valid only while PREADY=1
//  PREADY   out  1       transfer completes in this cycle
//  PSLVERR  out  1       error response, valid only while PREADY=1
// BEHAVIOUR
//  - Reset: state IDLE, regs[*]=0, wr_count=0, PRDATA=0, PREADY=0, PSLVERR=0; reset wins over any transfer in flight.
//  - Address map: idx=PADDR[ADDR_W-1:2].
//    idx<NUM_REGS is RW.
//    idx==NUM_REGS (0x10) is the RO wr_count.
//    Any other address, or PADDR[1:0]!=0, is an error.
//  - FSM states: IDLE, WAIT, READY. All outputs are driven from flops (no comb path from inputs).
//  - IDLE: PSEL=1 & PENABLE=0 (setup) -> latch addr/write/wdata, cnt<=WAIT_CYCLES.
//    Next state is READY if WAIT_CYCLES==0, else WAIT.
//    PENABLE=1 without a prior setup is ignored; stay IDLE.
//  - WAIT: cnt decrements each cycle; cnt==1 -> READY. PSEL=0 -> abort to IDLE, no side effects.
//  - READY: PREADY=1 for exactly one cycle. PRDATA and PSLVERR are registered on entry to READY.
//    Commit happens on the edge leaving READY.
//    Next state: setup present -> latch and go WAIT/READY (back-to-back, no idle gap); else IDLE.
//  - Latency: PREADY is high in access cycle WAIT_CYCLES+1 (setup cycle not counted).
//  - Write commit: valid RW idx -> regs[idx]<=wdata and wr_count<=wr_count+1 (wraps 0xFFFF_FFFF->0).
//    Error write or write to 0x10 -> PSLVERR=1, no register changes, wr_count unchanged.
//  - Read: valid idx -> PRDATA=regs[idx] or wr_count. Error -> PRDATA=0, PSLVERR=1.
//    Outside READY, PRDATA=0.
//  - Inputs latched at setup are used; changes to PADDR/PWDATA during WAIT are ignored.
// STRUCTURE
//  - apb_pkg: state enum {IDLE,WAIT,READY}; offset constants NUMBER_OFS=0, DATE_OFS=4,
//    SURNAME_OFS=8, NAME_OFS=12, WRCNT_OFS=16; DATA_W default.
//  - Sub-module apb_regbank: NUM_REGS x DATA_W storage, write port + comb read mux + wr_count.
//    The FSM, wait counter and decode stay in the top module.
// TESTING
//  - Reset: PRESET=1 for 2 cycles mid-WAIT -> PREADY=0, PSLVERR=0, all regs read back 0.
//  - Writes: 21@0x0, 0x08112023@0x4, 0x91A0E9A8@0x8, 0x80E0E2F1@0xC with WAIT_CYCLES=1
//    -> PREADY high exactly 2 cycles after each setup, PSLVERR=0.
//    Read-back returns the same values; read of 0x10 returns 4.
//  - WAIT_CYCLES=0 and WAIT_CYCLES=3 -> PREADY in access cycle 1 and 4 respectively;
//    master holds PENABLE until then.
//  - Errors: write to 0x14 and to 0x2 -> PSLVERR=1, PRDATA=0.
//    Write to 0x10 -> PSLVERR=1 and the read of 0x10 is unchanged.
//  - Abort: PSEL dropped during WAIT on a write of 0xDEADBEEF@0x4 -> no PREADY, reg 0x4 keeps its old value.
//  - Back-to-back: setup presented in the READY cycle -> second transfer completes
//    with no IDLE cycle between; wr_count +2.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and register offsets for the APB wait-state completer
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_state_e;

  localparam int APB_DATA_W = 32;

  localparam logic [7:0] NUMBER_OFS  = 8'h00;
  localparam logic [7:0] DATE_OFS    = 8'h04;
  localparam logic [7:0] SURNAME_OFS = 8'h08;
  localparam logic [7:0] NAME_OFS    = 8'h0C;
  localparam logic [7:0] WRCNT_OFS   = 8'h10;

endpackage

// File: rtl/apb_regbank.sv
// rtl/apb_regbank.sv - RW register storage with a single write port, comb read mux and write counter
module apb_regbank
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = APB_DATA_W,
  parameter int IDX_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] wr_count_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] wr_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (we_i) begin
      regs_q[widx_i] <= wdata_i;
      wr_count_q     <= wr_count_q + DATA_W'(1);
    end
  end

  // Index space may exceed NUM_REGS when it is not a power of two.
  assign rdata_o    = ({1'b0, ridx_i} < (IDX_W+1)'(NUM_REGS)) ? regs_q[ridx_i] : '0;
  assign wr_count_o = wr_count_q;

endmodule

// File: rtl/apb_wait_slave.sv
// rtl/apb_wait_slave.sv - APB completer with programmable PREADY wait states and PSLVERR decode
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] CNT_IDX   = IDX_W'(NUM_REGS);
  localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  logic              setup, latch, enter_ready;
  logic [ADDR_W-1:0] src_addr;
  logic              src_write, src_rw, src_cnt, cur_rw, commit_we;
  logic [IDX_W-1:0]  src_idx, cur_idx;
  logic [DATA_W-1:0] bank_rdata, wr_count, rd_val;

  // Response is computed from the address being latched this edge when a new setup arrives.
  assign setup     = PSEL & ~PENABLE;
  assign latch     = setup && (state_q != WAIT);
  assign src_addr  = latch ? PADDR : addr_q;
  assign src_write = latch ? PWRITE : write_q;
  assign src_idx   = src_addr[ADDR_W-1:2];
  assign src_rw    = (src_addr[1:0] == 2'b00) && (src_idx < CNT_IDX);
  assign src_cnt   = (src_addr[1:0] == 2'b00) && (src_idx == CNT_IDX);
  assign cur_idx   = addr_q[ADDR_W-1:2];
  assign cur_rw    = (addr_q[1:0] == 2'b00) && (cur_idx < CNT_IDX);
  assign commit_we = (state_q == READY) && write_q && cur_rw;

  apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (RIDX_W)
  ) u_regbank (
    .clk_i      (PCLK),
    .rst_i      (PRESET),
    .we_i       (commit_we),
    .widx_i     (cur_idx[RIDX_W-1:0]),
    .wdata_i    (wdata_q),
    .ridx_i     (src_idx[RIDX_W-1:0]),
    .rdata_o    (bank_rdata),
    .wr_count_o (wr_count)
  );

  // Forward a write committing on this same edge into a back-to-back read.
  always_comb begin
    rd_val = bank_rdata;
    if (src_cnt) begin
      rd_val = commit_we ? wr_count + DATA_W'(1) : wr_count;
    end else if (commit_we && (src_idx == cur_idx)) begin
      rd_val = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    enter_ready = 1'b0;
    case (state_q)
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d     = READY;
          enter_ready = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (setup) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d     = READY;
            enter_ready = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
    endcase

    pready_d  = enter_ready;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (enter_ready) begin
      if (src_write) begin
        pslverr_d = !src_rw;
      end else begin
        pslverr_d = !(src_rw || src_cnt);
        prdata_d  = pslverr_d ? '0 : rd_val;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// tb/tb_apb_wait_slave.sv - self-checking bench for apb_wait_slave at 0, 1 and 3 wait states
module tb_apb_wait_slave;
  import apb_pkg::*;

  localparam int WCS [3] = '{0, 1, 3};

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_regs [3][4];
  logic [31:0] m_cnt  [3];

  always #5 PCLK = ~PCLK;

  apb_wait_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(4), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_wait_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(4), .WAIT_CYCLES(1)) u_w1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_wait_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(4), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: address rules applied directly to arrays.
  function automatic void model(input int d, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int unsigned idx;
    idx = addr / 4;
    rd  = '0;
    err = 1'b0;
    if (addr % 4 != 0) err = 1'b1;
    else if (wr) begin
      if (idx < 4) begin
        m_regs[d][idx] = wdata;
        m_cnt[d]       = m_cnt[d] + 1;
      end else err = 1'b1;
    end else if (idx < 4) rd = m_regs[d][idx];
    else if (idx == 4) rd = m_cnt[d];
    else err = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = '0;
      for (int i = 0; i < 4; i++) m_regs[d][i] = '0;
    end
  endfunction

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic err);
    int   lat;
    logic done;
    @(posedge PCLK); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge PCLK); #1;
    penable[d] = 1'b1; paddr[d] = $urandom; pwdata[d] = $urandom;
    lat = 0; done = 1'b0; rd = '0; err = 1'b0;
    while (!done && lat < 40) begin
      lat++;
      @(negedge PCLK);
      if (pready[d]) begin
        done = 1'b1; rd = prdata[d]; err = pslverr[d];
      end else begin
        chk($sformatf("idle_prdata_w%0d", WCS[d]), prdata[d], 32'h0);
        @(posedge PCLK); #1;
      end
    end
    chk($sformatf("lat_w%0d", WCS[d]), done ? 32'(lat) : 32'hFFFF_FFFF, 32'(WCS[d] + 1));
    @(posedge PCLK); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic op(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd, rd;
    logic        exp_err, err;
    model(d, wr, addr, wdata, exp_rd, exp_err);
    xfer(d, wr, addr, wdata, rd, err);
    chk($sformatf("w%0d_%s_%08h_rdata", WCS[d], wr ? "wr" : "rd", addr), rd, exp_rd);
    chk($sformatf("w%0d_%s_%08h_err", WCS[d], wr ? "wr" : "rd", addr), 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] rd, dummy_rd;
    logic        err, dummy_err;
    int          d, r;
    logic [31:0] a;

    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
    end
    model_reset();

    vecs[0]  = '{1'b1, 32'(NUMBER_OFS),  32'd21,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'(DATE_OFS),    32'h08112023,  32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'(SURNAME_OFS), 32'h91A0E9A8,  32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'(NAME_OFS),    32'h80E0E2F1,  32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'(NUMBER_OFS),  32'h0,         32'd21,       1'b0};
    vecs[5]  = '{1'b0, 32'(DATE_OFS),    32'h0,         32'h08112023, 1'b0};
    vecs[6]  = '{1'b0, 32'(SURNAME_OFS), 32'h0,         32'h91A0E9A8, 1'b0};
    vecs[7]  = '{1'b0, 32'(NAME_OFS),    32'h0,         32'h80E0E2F1, 1'b0};
    vecs[8]  = '{1'b0, 32'(WRCNT_OFS),   32'h0,         32'd4,        1'b0};
    vecs[9]  = '{1'b1, 32'h14,           32'h12345678,  32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h2,            32'h12345678,  32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'(WRCNT_OFS),   32'h55AA55AA,  32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'(WRCNT_OFS),   32'h0,         32'd4,        1'b0};
    vecs[13] = '{1'b0, 32'h6,            32'h0,         32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h20,           32'h0,         32'h0,        1'b1};

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pready_%0d", i), 32'(pready[i]), 32'h0);
      chk($sformatf("rst_pslverr_%0d", i), 32'(pslverr[i]), 32'h0);
      chk($sformatf("rst_prdata_%0d", i), prdata[i], 32'h0);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      model(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, dummy_rd, dummy_err);
      xfer(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    op(0, 1'b1, 32'h0, 32'hCAFE0001);
    op(0, 1'b0, 32'h0, 32'h0);
    op(2, 1'b1, 32'hC, 32'hBEEF0003);
    op(2, 1'b0, 32'hC, 32'h0);

    // Abort: PSEL drops in the WAIT cycle that follows the setup.
    @(posedge PCLK); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h4; pwdata[1] = 32'hDEADBEEF;
    @(posedge PCLK); #1;
    psel[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk($sformatf("abort_pready_%0d", i), 32'(pready[1]), 32'h0);
    end
    xfer(1, 1'b0, 32'h4, 32'h0, rd, err);
    chk("abort_reg4", rd, 32'h08112023);
    xfer(1, 1'b0, 32'h10, 32'h0, rd, err);
    chk("abort_wrcnt", rd, 32'd4);

    // Back-to-back: second setup presented during the READY cycle of the first.
    model(1, 1'b1, 32'h8, 32'h11, dummy_rd, dummy_err);
    model(1, 1'b1, 32'hC, 32'h22, dummy_rd, dummy_err);
    @(posedge PCLK); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'h11;
    @(posedge PCLK); #1;
    penable[1] = 1'b1;
    @(negedge PCLK);
    chk("b2b_first_wait", 32'(pready[1]), 32'h0);
    @(posedge PCLK); #1;
    penable[1] = 1'b0; paddr[1] = 32'hC; pwdata[1] = 32'h22;
    @(negedge PCLK);
    chk("b2b_first_ready", 32'(pready[1]), 32'h1);
    chk("b2b_first_err", 32'(pslverr[1]), 32'h0);
    @(posedge PCLK); #1;
    penable[1] = 1'b1;
    @(negedge PCLK);
    chk("b2b_second_wait", 32'(pready[1]), 32'h0);
    @(negedge PCLK);
    chk("b2b_second_ready", 32'(pready[1]), 32'h1);
    chk("b2b_second_err", 32'(pslverr[1]), 32'h0);
    @(posedge PCLK); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    xfer(1, 1'b0, 32'h8, 32'h0, rd, err);
    chk("b2b_reg8", rd, 32'h11);
    xfer(1, 1'b0, 32'hC, 32'h0, rd, err);
    chk("b2b_regC", rd, 32'h22);
    xfer(1, 1'b0, 32'h10, 32'h0, rd, err);
    chk("b2b_wrcnt", rd, 32'd6);

    for (int n = 0; n < 120; n++) begin
      d = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r <= 4) a = 32'(r * 4);
      else if (r <= 6) a = 32'($urandom_range(0, 4) * 4 + $urandom_range(1, 3));
      else a = 32'($urandom_range(5, 20) * 4);
      op(d, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Reset held for two cycles while a W=3 write sits in WAIT.
    @(posedge PCLK); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h0; pwdata[2] = 32'h5A;
    @(posedge PCLK); #1;
    penable[2] = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      chk($sformatf("midrst_pready_%0d", i), 32'(pready[2]), 32'h0);
      chk($sformatf("midrst_pslverr_%0d", i), 32'(pslverr[2]), 32'h0);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk($sformatf("postrst_pready_%0d", i), 32'(pready[2]), 32'h0);
    end
    @(posedge PCLK); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 5; k++) begin
        xfer(i, 1'b0, 32'(k * 4), 32'h0, rd, err);
        chk($sformatf("rstread_w%0d_%0d", WCS[i], k * 4), rd, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
